// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard/forwarding controller.
//   FWD_REGFILE  : forward-select value meaning "take the operand from the regfile"
//   sb_entry_t   : one in-flight register writer tracked by the scoreboard
//   hazard_pri_e : which pipeline-control action wins this cycle
package pipe_ctrl_pkg;

  localparam int FWD_REGFILE = 0;

  // Entries are sized for the widest supported configuration (AW <= 8,
  // LOAD_LAT <= 4); narrower addresses are zero-extended on insert.
  localparam int SB_AW = 8;
  localparam int LAT_W = 3;

  typedef struct packed {
    logic             valid;
    logic [SB_AW-1:0] addr;
    logic             wen;
    logic             is_load;
    logic [LAT_W-1:0] lat;      // cycles until the result can be forwarded
  } sb_entry_t;

  // Highest priority last so the encoding reads in escalation order.
  typedef enum logic [1:0] {
    PRI_NONE,
    PRI_FLUSH,
    PRI_STALL,
    PRI_HOLD
  } hazard_pri_e;

endpackage

// File: rtl/hazard_scoreboard.sv
// Scoreboard of in-flight register writers, one entry per stage after ID.
// Entry 1 is EXE, entry FWD_DEPTH is the last stage that can still forward.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   advance               shift the entries one stage
//   ins_*                 instruction entering entry 1 (ins_valid=0 -> bubble)
//   rs_used/rs_addr       first source query
//   rt_used/rt_addr       second source query
//   *_hit/*_stage/*_lat   nearest matching writer, its stage and remaining latency
module hazard_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter int AW        = 5,
  parameter int FWD_DEPTH = 3,
  parameter int LOAD_LAT  = 1,
  parameter int SELW      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic             ins_valid,
  input  logic [AW-1:0]    ins_addr,
  input  logic             ins_wen,
  input  logic             ins_is_load,
  input  logic             rs_used,
  input  logic [AW-1:0]    rs_addr,
  input  logic             rt_used,
  input  logic [AW-1:0]    rt_addr,
  output logic             rs_hit,
  output logic [SELW-1:0]  rs_stage,
  output logic [LAT_W-1:0] rs_lat,
  output logic             rt_hit,
  output logic [SELW-1:0]  rt_stage,
  output logic [LAT_W-1:0] rt_lat
);

  sb_entry_t sb_q [1:FWD_DEPTH];
  sb_entry_t ins_entry;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    ins_entry = '0;
    if (ins_valid) begin
      ins_entry.valid   = 1'b1;
      ins_entry.addr    = SB_AW'(ins_addr);
      ins_entry.wen     = ins_wen;
      ins_entry.is_load = ins_is_load;
      ins_entry.lat     = ins_is_load ? LAT_W'(LOAD_LAT) : '0;
    end
  end

  function automatic sb_entry_t age(input sb_entry_t e);
    sb_entry_t r;
    r = e;
    if (e.lat != '0) r.lat = e.lat - 1'b1;
    return r;
  endfunction

  // NOTE: this array is control state, not data storage; it must be cleared
  // on reset or stale writers would forward/stall after reset.
  // NOTE: sequential state uses non-blocking assignments so every entry
  // samples its neighbour's pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= FWD_DEPTH; k++) sb_q[k] <= '0;
    end else if (advance) begin
      sb_q[1] <= ins_entry;
      for (int k = 2; k <= FWD_DEPTH; k++) sb_q[k] <= age(sb_q[k-1]);
    end
  end

  // Search from the oldest stage down so the youngest (lowest k) match wins.
  // Register 0 is hard-wired and never forwarded.
  function automatic void match_src(input  logic             used,
                                    input  logic [AW-1:0]    addr,
                                    output logic             hit,
                                    output logic [SELW-1:0]  stage,
                                    output logic [LAT_W-1:0] lat);
    hit   = 1'b0;
    stage = SELW'(FWD_REGFILE);
    lat   = '0;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (used && (addr != '0) && sb_q[k].valid && sb_q[k].wen &&
          (sb_q[k].addr == SB_AW'(addr))) begin
        hit   = 1'b1;
        stage = SELW'(k);
        lat   = sb_q[k].lat;
      end
    end
  endfunction

  always_comb begin
    match_src(rs_used, rs_addr, rs_hit, rs_stage, rs_lat);
    match_src(rt_used, rt_addr, rt_hit, rt_stage, rt_lat);
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller for the in-order MIPS pipeline.
// Tracks in-flight writers in a scoreboard and drives stage enables/clears,
// operand forward selects, a branch-flush sequencer and debug single-step.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   debug_en, debug_step         hold the pipeline; one advance per step rising edge
//   id_*                         decoded fields of the instruction in ID
//   if_en..wb_en                 stage enables
//   if_rst..wb_rst               stage synchronous clears
//   fwd_rs, fwd_rt               0 = regfile, k = result of scoreboard stage k
//   fwd_mem_ctrl                 store data taken from the load currently in MEM
//   stall_cnt, flush_cnt         load-use stall / branch flush cycle counters
module pipe_hazard_unit
  import pipe_ctrl_pkg::*;
#(
  parameter  int AW        = 5,
  parameter  int FWD_DEPTH = 3,
  parameter  int LOAD_LAT  = 1,
  parameter  int BR_FLUSH  = 1,
  parameter  int CNT_W     = 32,
  localparam int SELW      = $clog2(FWD_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             debug_en,
  input  logic             debug_step,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_rs_addr,
  input  logic [AW-1:0]    id_rt_addr,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic [AW-1:0]    id_wb_addr,
  input  logic             id_wb_wen,
  input  logic             id_is_load,
  input  logic             id_is_store,
  input  logic             id_ctrl_xfer,
  output logic             if_en,
  output logic             id_en,
  output logic             exe_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic             if_rst,
  output logic             id_rst,
  output logic             exe_rst,
  output logic             mem_rst,
  output logic             wb_rst,
  output logic [SELW-1:0]  fwd_rs,
  output logic [SELW-1:0]  fwd_rt,
  output logic             fwd_mem_ctrl,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic             step_q, step_edge, hold, advance;
  logic [1:0]       flush_q;
  logic             flush_active, flush_req;
  logic             rs_hit, rt_hit;
  logic [SELW-1:0]  rs_stage, rt_stage;
  logic [LAT_W-1:0] rs_lat, rt_lat;
  logic             store_fwd, rs_stall, rt_stall, stall;
  hazard_pri_e      pri;

  assign step_edge    = debug_step & ~step_q;
  assign hold         = debug_en & ~step_edge;
  assign advance      = ~hold;
  assign flush_active = (flush_q != '0);
  assign flush_req    = id_ctrl_xfer & (BR_FLUSH != 0);

  hazard_scoreboard #(
    .AW        (AW),
    .FWD_DEPTH (FWD_DEPTH),
    .LOAD_LAT  (LOAD_LAT),
    .SELW      (SELW)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .advance     (advance),
    // A stalled or flushed ID slot enters EXE as a bubble.
    .ins_valid   (id_valid & ~stall & ~flush_active),
    .ins_addr    (id_wb_addr),
    .ins_wen     (id_wb_wen),
    .ins_is_load (id_is_load),
    .rs_used     (id_rs_used),
    .rs_addr     (id_rs_addr),
    .rt_used     (id_rt_used),
    .rt_addr     (id_rt_addr),
    .rs_hit      (rs_hit),
    .rs_stage    (rs_stage),
    .rs_lat      (rs_lat),
    .rt_hit      (rt_hit),
    .rt_stage    (rt_stage),
    .rt_lat      (rt_lat)
  );

  // A store whose data comes from a load one cycle from completion need not
  // wait: the load result is handed to the store in MEM instead.
  always_comb begin
    store_fwd = rt_hit && id_is_store && (rt_stage == SELW'(1)) && (rt_lat == LAT_W'(1));
    rs_stall  = rs_hit && (rs_lat != '0);
    rt_stall  = rt_hit && (rt_lat != '0) && !store_fwd;
    stall     = rs_stall || rt_stall;
  end

  always_comb begin
    if (hold)                             pri = PRI_HOLD;
    else if (stall)                       pri = PRI_STALL;
    else if (flush_active || flush_req)   pri = PRI_FLUSH;
    else                                  pri = PRI_NONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q    <= 1'b0;
      flush_q   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      step_q <= debug_step;
      if (pri == PRI_STALL) stall_cnt <= stall_cnt + CNT_W'(1);
      if (pri == PRI_FLUSH) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
        // The transfer cycle itself is the first flush slot.
        flush_q   <= flush_active ? flush_q - 2'd1 : 2'(BR_FLUSH - 1);
      end
    end
  end

  always_comb begin
    {if_en, id_en, exe_en, mem_en, wb_en}      = '1;
    {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = '0;
    fwd_rs       = (rs_hit && rs_lat == '0) ? rs_stage : SELW'(FWD_REGFILE);
    fwd_rt       = (rt_hit && rt_lat == '0 && !store_fwd) ? rt_stage : SELW'(FWD_REGFILE);
    fwd_mem_ctrl = store_fwd;
    case (pri)
      PRI_HOLD:  {if_en, id_en, exe_en, mem_en, wb_en} = '0;
      PRI_STALL: begin
        if_en   = 1'b0;
        id_en   = 1'b0;
        exe_rst = 1'b1;
      end
      PRI_FLUSH: id_rst = 1'b1;
      default:   ;
    endcase
    if (!rst_n) begin
      {if_en, id_en, exe_en, mem_en, wb_en}      = '1;
      {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = '1;
      fwd_rs       = SELW'(FWD_REGFILE);
      fwd_rt       = SELW'(FWD_REGFILE);
      fwd_mem_ctrl = 1'b0;
    end
  end

endmodule
